// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
//
// Responder end of the L2-to-main-memory link. Accepts single-word 64-bit
// fetch and write requests, holds them for a fixed LATENCY, then completes
// them against an internal word-addressed array. A one-cycle mainValid pulse
// marks every completion. mainData carries the fetched word and holds it
// until the next fetch completes.
//
// Parameters
//   ADDRESS_LENGTH : byte-address width, must match the L2 cache
//   MEMORY_WORDS   : number of 64-bit words stored (power of two, >= 2)
//   LATENCY        : cycles from acceptance to completion pulse (1..255)
//
// Ports
//   clk            in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   doMainFetch    in   read request (level), sampled only in IDLE
//   doMainWrite    in   write request (level), sampled only in IDLE; wins over fetch
//   mainAddress    in   byte address; bits [2:0] and bits above the index ignored
//   mainDataWrite  in   write data
//   mainData       out  last fetched word
//   mainValid      out  one-cycle completion pulse (fetch and write)
//   mainBusy       out  high while a request is in flight
// -----------------------------------------------------------------------------
module main_memory_responder #(
   parameter int ADDRESS_LENGTH = 56,
   parameter int MEMORY_WORDS   = 4096,
   parameter int LATENCY        = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      doMainFetch,
   input  logic                      doMainWrite,
   input  logic [ADDRESS_LENGTH-1:0] mainAddress,
   input  logic [63:0]               mainDataWrite,
   output logic [63:0]               mainData,
   output logic                      mainValid,
   output logic                      mainBusy
);

   localparam int INDEX_W = $clog2(MEMORY_WORDS);

   // Countdown register is 8 bits wide, enough for the largest legal LATENCY.
   localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t               r_state;
   logic [7:0]           r_count;
   logic [INDEX_W-1:0]   r_index;
   logic [63:0]          r_wdata;
   logic                 r_is_write;
   logic [63:0]          r_data;
   logic                 r_valid;
   logic                 r_busy;

   logic [63:0]          r_mem [MEMORY_WORDS];

   logic                 w_accept;
   logic                 w_complete;
   logic [INDEX_W-1:0]   w_req_index;
   logic                 w_unused_addr;

   // Only the word-index bits of the address select storage: the byte offset
   // rounds down and the upper bits alias modulo MEMORY_WORDS*8.
   assign w_req_index   = mainAddress[3 +: INDEX_W];
   assign w_unused_addr = ^mainAddress;

   assign w_accept   = (r_state == ST_IDLE) && (doMainFetch || doMainWrite);
   // Last WAIT cycle: the edge that ends it performs the array access.
   assign w_complete = (r_state == ST_WAIT) && (r_count == 8'd0);

   // -------------------------------------------------------------------------
   // Control FSM and registered outputs
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_count    <= 8'd0;
         r_index    <= '0;
         r_wdata    <= 64'd0;
         r_is_write <= 1'b0;
         r_data     <= 64'd0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_valid <= 1'b0;
               if (w_accept) begin
                  // Write has priority; a concurrent fetch stays pending and
                  // is picked up on a later IDLE visit if still asserted.
                  r_is_write <= doMainWrite;
                  r_index    <= w_req_index;
                  r_wdata    <= mainDataWrite;
                  r_count    <= COUNT_LOAD;
                  r_busy     <= 1'b1;
                  r_state    <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (r_count == 8'd0) begin
                  r_valid <= 1'b1;
                  if (!r_is_write) begin
                     r_data <= r_mem[r_index];
                  end
                  r_state <= ST_RESP;
               end else begin
                  r_count <= r_count - 8'd1;
               end
            end

            ST_RESP: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Storage array
   // -------------------------------------------------------------------------
   // NOTE: the array has no reset branch; contents survive reset and map onto
   // plain RAM. Reset still gates the write so an in-flight write is dropped.
   always_ff @(posedge clk) begin
      if (!reset && w_complete && r_is_write) begin
         r_mem[r_index] <= r_wdata;
      end
   end

   assign mainData  = r_data;
   assign mainValid = r_valid;
   assign mainBusy  = r_busy;

endmodule

// File: tb/tb_main_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_main_memory_responder
//
// Directed and random stimulus for main_memory_responder (MEMORY_WORDS=16 so
// address aliasing is reachable). Expected values come from a word-array
// reference model indexed by (byte_address / 8) mod MEMORY_WORDS.
// -----------------------------------------------------------------------------
module tb_main_memory_responder;

   localparam int AW    = 56;
   localparam int WORDS = 16;
   localparam int LAT   = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          doMainFetch;
   logic          doMainWrite;
   logic [AW-1:0] mainAddress;
   logic [63:0]   mainDataWrite;
   logic [63:0]   mainData;
   logic          mainValid;
   logic          mainBusy;

   int            n_tests = 0;
   int            n_fail  = 0;

   // Reference model state
   logic [63:0]   ref_mem [WORDS];
   logic [63:0]   exp_data;

   main_memory_responder #(
      .ADDRESS_LENGTH (AW),
      .MEMORY_WORDS   (WORDS),
      .LATENCY        (LAT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .doMainFetch   (doMainFetch),
      .doMainWrite   (doMainWrite),
      .mainAddress   (mainAddress),
      .mainDataWrite (mainDataWrite),
      .mainData      (mainData),
      .mainValid     (mainValid),
      .mainBusy      (mainBusy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [AW-1:0] a);
      return int'((a / 8) % WORDS);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a completion pulse; also counts cycles with busy low.
   task automatic wait_valid(output int cycles, output int busy_low);
      bit seen;
      seen     = 1'b0;
      cycles   = 0;
      busy_low = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         cycles++;
         if (!mainBusy) busy_low++;
         seen = mainValid;
      end
   endtask

   // One complete request from an idle DUT; leaves the DUT idle again.
   task automatic transact(input bit is_write, input logic [AW-1:0] a,
                           input logic [63:0] d, input string tag);
      int cyc;
      int blow;
      doMainWrite   = is_write;
      doMainFetch   = !is_write;
      mainAddress   = a;
      mainDataWrite = d;
      tick();
      doMainWrite = 1'b0;
      doMainFetch = 1'b0;
      check({tag, " busy_at_accept"}, 64'(mainBusy), 64'd1);
      wait_valid(cyc, blow);
      check({tag, " latency"}, 64'(cyc), 64'(LAT));
      check({tag, " busy_held"}, 64'(blow), 64'd0);
      if (is_write) ref_mem[widx(a)] = d;
      else          exp_data = ref_mem[widx(a)];
      check({tag, " data"}, mainData, exp_data);
      tick();
      check({tag, " valid_drop"}, 64'(mainValid), 64'd0);
      check({tag, " busy_drop"}, 64'(mainBusy), 64'd0);
      check({tag, " data_hold"}, mainData, exp_data);
   endtask

   initial begin
      int cyc;
      int blow;
      int pulses;

      reset         = 1'b1;
      doMainFetch   = 1'b1;   // reset must win over a request
      doMainWrite   = 1'b0;
      mainAddress   = '0;
      mainDataWrite = '0;
      exp_data      = 64'd0;
      tick();
      tick();
      check("reset data", mainData, 64'd0);
      check("reset valid", 64'(mainValid), 64'd0);
      check("reset busy_over_request", 64'(mainBusy), 64'd0);
      doMainFetch = 1'b0;
      reset       = 1'b0;
      tick();

      // Write then fetch at 0x40
      transact(1'b1, 56'h40, 64'h0123_4567_89AB_CDEF, "wr40");
      check("wr40 data_unchanged", mainData, 64'd0);
      transact(1'b0, 56'h40, 64'd0, "rd40");
      check("rd40 const", mainData, 64'h0123_4567_89AB_CDEF);

      // Line walk with fetch held high
      for (int k = 0; k < 4; k++)
         transact(1'b1, 56'h100 + 56'(8 * k), 64'hA0 + 64'(k), "walk_wr");
      doMainFetch = 1'b1;
      mainAddress = 56'h100;
      for (int k = 0; k < 4; k++) begin
         wait_valid(cyc, blow);
         check("walk gap", 64'(cyc), (k == 0) ? 64'(LAT + 1) : 64'(LAT + 2));
         exp_data = ref_mem[widx(mainAddress)];
         check("walk data", mainData, exp_data);
         check("walk data_const", mainData, 64'hA0 + 64'(k));
         if (k == 3) doMainFetch = 1'b0;
         else        mainAddress = mainAddress + 56'd8;
      end
      tick();
      check("walk end_busy", 64'(mainBusy), 64'd0);

      // Simultaneous fetch and write: write wins, fetch follows
      doMainFetch   = 1'b1;
      doMainWrite   = 1'b1;
      mainAddress   = 56'h200;
      mainDataWrite = 64'h55;
      tick();
      doMainWrite = 1'b0;
      check("both busy", 64'(mainBusy), 64'd1);
      wait_valid(cyc, blow);
      check("both write_latency", 64'(cyc), 64'(LAT));
      check("both write_first", mainData, exp_data);
      ref_mem[widx(56'h200)] = 64'h55;
      wait_valid(cyc, blow);
      check("both fetch_gap", 64'(cyc), 64'(LAT + 2));
      exp_data = ref_mem[widx(56'h200)];
      check("both fetch_data", mainData, 64'h55);
      doMainFetch = 1'b0;
      tick();
      check("both end_busy", 64'(mainBusy), 64'd0);

      // Aliasing and misalignment
      transact(1'b1, 56'h08, 64'h77, "alias_wr");
      transact(1'b0, 56'h8D, 64'd0, "alias_rd");
      check("alias const", mainData, 64'h77);

      // Reset two cycles into WAIT discards the write
      transact(1'b1, 56'h300, 64'h11, "old_wr");
      doMainWrite   = 1'b1;
      mainAddress   = 56'h300;
      mainDataWrite = 64'h99;
      tick();
      doMainWrite = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      exp_data = 64'd0;
      check("rst_mid data", mainData, 64'd0);
      check("rst_mid valid", 64'(mainValid), 64'd0);
      check("rst_mid busy", 64'(mainBusy), 64'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (mainValid) pulses++;
      end
      check("rst_mid no_pulse", 64'(pulses), 64'd0);
      transact(1'b0, 56'h300, 64'd0, "rst_mid_rd");
      check("rst_mid old_value", mainData, 64'h11);

      // Random traffic: fill every word, then mixed operations
      for (int w = 0; w < WORDS; w++)
         transact(1'b1, 56'(w * 8) + 56'($urandom_range(0, 7)),
                  {$urandom(), $urandom()}, "fill");
      for (int i = 0; i < 40; i++)
         transact(1'($urandom_range(0, 1)), {24'($urandom()), $urandom()},
                  {$urandom(), $urandom()}, "rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Responder end of the L2-to-main-memory interface: accepts single-word 64-bit fetch and write requests issued by the L2 cache on `doMainFetch`/`doMainWrite`, serves them from an internal word-addressed array after a fixed, parameterised latency, and returns read data with a one-cycle completion pulse. It sits below the L2 cache and serves as both the main-memory model for simulation and the synthesizable backing store for small configurations. Multi-word line fills are performed by the L2 as a sequence of single-word requests at consecutive 8-byte addresses.

## Interface
- `ADDRESS_LENGTH`, 56, byte-address width; must match the L2 cache.
- `MEMORY_WORDS`, 4096, number of 64-bit words stored; power of two, ≥2.
- `LATENCY`, 4, cycles from request acceptance to completion pulse; legal range 1..255.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `doMainFetch`  in  1  read request, level; sampled only in IDLE.
- `doMainWrite`  in  1  write request, level; sampled only in IDLE.
- `mainAddress`  in  ADDRESS_LENGTH  byte address of the request.
- `mainDataWrite`  in  64  write data.
- `mainData`  out  64  read data; valid while `mainValid` is high after a fetch.
- `mainValid`  out  1  one-cycle completion pulse, for both fetches and writes.
- `mainBusy`  out  1  high whenever a request is in flight (state ≠ IDLE).

## Operation
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE: if `doMainWrite` or `doMainFetch` is high at an edge, accept the request:
  - Capture the address, the write data, and the operation.
  - Load `count` = LATENCY−1.
  - Go to WAIT.
  - If both requests are high, the write wins. The fetch stays unaccepted and is taken at a later IDLE edge if still asserted.
- WAIT: if `count` = 0, go to RESP at the next edge; otherwise decrement. Input changes during WAIT/RESP are ignored. The captured values are used.
- Entering RESP (the edge leaving WAIT):
  - Set `mainValid` = 1.
  - Fetch: load `mainData` from the array.
  - Write: update the array word.
- RESP: always returns to IDLE at the next edge, and `mainValid` clears.
- Word index = captured address bits [3 +: log2(MEMORY_WORDS)]:
  - Bits [2:0] are ignored, so misaligned addresses round down to the word.
  - Upper bits are ignored, so addresses alias modulo MEMORY_WORDS×8.
- Requests held high continuously are re-accepted on every IDLE visit. The initiator drops the request or changes `mainAddress` between words; this is how the L2 walks a line.
- `mainData` holds its last fetched value until the next fetch completes. A write completion does not change `mainData`.

## Timing
- Reset values:
  - `mainData` = 0, `mainValid` = 0, `mainBusy` = 0.
  - State = IDLE, `count` = 0.
  - Captured registers = 0.
- Array contents are not cleared by reset; they are undefined at power-up and preserved across reset.
- Request accepted at edge t0:
  - `mainBusy` rises at t0.
  - `mainValid` is high from edge t0+LATENCY to t0+LATENCY+1.
  - `mainBusy` falls at t0+LATENCY+1.
- Earliest next acceptance is edge t0+LATENCY+2. Sustained throughput is one word per LATENCY+2 cycles.
- A write completing at edge t0+LATENCY is visible to any fetch accepted afterwards.
- Reset mid-operation: return to IDLE immediately and clear all outputs. A pending write is discarded and the array is not updated.
- Reset has priority over request acceptance in the same cycle.

## Test plan
- Reset, then write `64'h0123_4567_89AB_CDEF` to address `0x40` with LATENCY=4. Required response:
  - `mainBusy` is high for 5 cycles.
  - `mainValid` pulses exactly once, 4 cycles after acceptance.
  - `mainData` remains 0.
- Fetch `0x40` after that write → `mainData` = `64'h0123_4567_89AB_CDEF` in the `mainValid` cycle, and it holds afterwards.
- Line walk: write words 0xA0..0xA3 to `0x100`, `0x108`, `0x110`, `0x118`. Hold `doMainFetch` high from `0x100` and advance the address by 8 after each pulse. Required response:
  - Four pulses, each LATENCY+2 cycles apart.
  - Data `0xA0`, `0xA1`, `0xA2`, `0xA3`, in that order.
- Assert fetch and write of `0x55` to `0x200` in the same IDLE cycle. Required response:
  - The write completes first.
  - The still-held fetch is then accepted and returns `0x55`.
- Aliasing and misalignment with MEMORY_WORDS=16: write `0x77` to `0x08`. A fetch of `0x8D` (misaligned, aliases word 1) returns `0x77`.
- Reset mid-write: begin a write of `0x99` to `0x300` over old value `0x11`, and assert reset 2 cycles into WAIT. Required response:
  - Outputs are 0 on the next edge.
  - `mainValid` never pulses.
  - A subsequent fetch of `0x300` returns `0x11`.
